// File: rtl/dot_product_sequencer_if.sv
// Bundle of the dot_product_sequencer request, memory read-port and result handshake signals.
// The sequencer side uses the slave modport; the driver/memory side uses master.
interface dot_product_sequencer_if;
  logic        start;
  logic [3:0]  sector_a;
  logic [3:0]  sector_b;
  logic        busy;
  logic [3:0]  read_add_1;
  logic [3:0]  read_add_2;
  logic [3:0]  read_sector_selector_1;
  logic [3:0]  read_sector_selector_2;
  logic [15:0] read_data_1;
  logic [15:0] read_data_2;
  logic [15:0] result;
  logic        result_valid;
  logic        result_ready;
  logic        overflow;

  modport slave (
    input  start, sector_a, sector_b, read_data_1, read_data_2, result_ready,
    output busy, read_add_1, read_add_2, read_sector_selector_1, read_sector_selector_2,
           result, result_valid, overflow
  );

  modport master (
    output start, sector_a, sector_b, read_data_1, read_data_2, result_ready,
    input  busy, read_add_1, read_add_2, read_sector_selector_1, read_sector_selector_2,
           result, result_valid, overflow
  );
endinterface

// File: rtl/dot_product_sequencer.sv
// Streams two vectors from the dual-port sector memory, accumulates their signed Q products,
// then rescales/saturates to 16 bits. Define DOT_PRODUCT_RELU_EN to zero negative results.
module dot_product_sequencer #(
  parameter int unsigned VEC_LEN      = 16,
  parameter int unsigned FRAC_BITS    = 8,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned ACC_WIDTH    = 40
) (
  input logic                    clock,
  input logic                    reset,
  dot_product_sequencer_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StIssue, StDrain, StScale, StDone} state_e;

  localparam int unsigned DrainW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic signed [ACC_WIDTH-1:0] SatMax = ACC_WIDTH'(32767);
  localparam logic signed [ACC_WIDTH-1:0] SatMin = ~SatMax;
  localparam logic [3:0] LastIdx = 4'(VEC_LEN - 1);
  localparam logic [DrainW-1:0] LastDrain = DrainW'(READ_LATENCY - 1);

  state_e                      state_q, state_d;
  logic [3:0]                  counter_q, counter_d;
  logic [3:0]                  sec_a_q, sec_a_d;
  logic [3:0]                  sec_b_q, sec_b_d;
  logic [DrainW-1:0]           drain_q, drain_d;
  logic [READ_LATENCY-1:0]     pipe_q, pipe_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [15:0]                 result_q, result_d;
  logic                        overflow_q, overflow_d;

  logic                        issue;
  logic [READ_LATENCY:0]       pipe_ext;
  logic signed [31:0]          op_a, op_b, product;
  logic signed [ACC_WIDTH-1:0] shifted;
  logic [15:0]                 sat;
  logic                        clamp;

  // Arithmetic datapath: product of the arriving pair and the saturated, rescaled sum.
  always_comb begin
    op_a    = {{16{bus.read_data_1[15]}}, bus.read_data_1};
    op_b    = {{16{bus.read_data_2[15]}}, bus.read_data_2};
    product = op_a * op_b;
    shifted = acc_q >>> FRAC_BITS;
    sat     = shifted[15:0];
    clamp   = 1'b0;
    if (shifted > SatMax) begin
      sat   = 16'h7fff;
      clamp = 1'b1;
    end else if (shifted < SatMin) begin
      sat   = 16'h8000;
      clamp = 1'b1;
    end
`ifdef DOT_PRODUCT_RELU_EN
    if (sat[15]) begin
      sat = 16'h0000;
    end
`endif
  end

  always_comb begin
    state_d    = state_q;
    counter_d  = counter_q;
    sec_a_d    = sec_a_q;
    sec_b_d    = sec_b_q;
    drain_d    = drain_q;
    acc_d      = acc_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    issue      = 1'b0;

    // Oldest pipe slot marks the cycle its read data is on the bus.
    if (pipe_q[READ_LATENCY-1]) begin
      acc_d = acc_q + {{(ACC_WIDTH-32){product[31]}}, product};
    end

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d   = StIssue;
          sec_a_d   = bus.sector_a;
          sec_b_d   = bus.sector_b;
          counter_d = '0;
          acc_d     = '0;
        end
      end
      StIssue: begin
        issue = 1'b1;
        if (counter_q == LastIdx) begin
          state_d = StDrain;
          drain_d = '0;
        end else begin
          counter_d = counter_q + 4'd1;
        end
      end
      StDrain: begin
        if (drain_q == LastDrain) begin
          state_d = StScale;
        end else begin
          drain_d = drain_q + DrainW'(1);
        end
      end
      StScale: begin
        result_d   = sat;
        overflow_d = clamp;
        state_d    = StDone;
      end
      StDone: begin
        if (bus.result_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    pipe_ext = {pipe_q, issue};
    pipe_d   = pipe_ext[READ_LATENCY-1:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      counter_q  <= '0;
      sec_a_q    <= '0;
      sec_b_q    <= '0;
      drain_q    <= '0;
      pipe_q     <= '0;
      acc_q      <= '0;
      result_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      counter_q  <= counter_d;
      sec_a_q    <= sec_a_d;
      sec_b_q    <= sec_b_d;
      drain_q    <= drain_d;
      pipe_q     <= pipe_d;
      acc_q      <= acc_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
    end
  end

  // Address and selectors come straight from state, so they hold through DRAIN.
  assign bus.busy                   = (state_q != StIdle);
  assign bus.read_add_1             = counter_q;
  assign bus.read_add_2             = counter_q;
  assign bus.read_sector_selector_1 = sec_a_q;
  assign bus.read_sector_selector_2 = sec_b_q;
  assign bus.result                 = result_q;
  assign bus.overflow               = overflow_q;
  assign bus.result_valid           = (state_q == StDone);

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Directed bench for dot_product_sequencer with a 1-cycle registered sector memory model.
module tb_dot_product_sequencer;
  localparam int unsigned VecLen = 16;

  logic clock;
  logic reset;
  int   compared   = 0;
  int   mismatched = 0;
  int   lat;

  logic [15:0] mem [16][16];

  dot_product_sequencer_if bus ();

  dot_product_sequencer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    bus.read_data_1 <= mem[bus.read_sector_selector_1][bus.read_add_1];
    bus.read_data_2 <= mem[bus.read_sector_selector_2][bus.read_add_2];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input int sec, input logic [15:0] val);
    for (int e = 0; e < 16; e++) mem[sec][e] = val;
  endtask

  // Latency counts clock edges starting with the one that samples start.
  task automatic run(input logic [3:0] sa, input logic [3:0] sb, input bit chk_addr,
                     output int cycles);
    logic [15:0] exp_addr;
    cycles           = 0;
    bus.start        = 1'b1;
    bus.sector_a     = sa;
    bus.sector_b     = sb;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clock);
      #1;
      bus.start = 1'b0;
      if (chk_addr && i <= VecLen + 1) begin
        exp_addr = {4'((i > VecLen) ? VecLen - 1 : i - 1),
                    4'((i > VecLen) ? VecLen - 1 : i - 1), sa, sb};
        check("issue_addr", {bus.read_add_1, bus.read_add_2, bus.read_sector_selector_1,
                             bus.read_sector_selector_2}, exp_addr);
      end
      if (bus.result_valid) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic accept();
    bus.result_ready = 1'b1;
    @(posedge clock);
    #1;
    bus.result_ready = 1'b0;
    check("accept_valid", bus.result_valid, 1'b0);
    check("accept_busy", bus.busy, 1'b0);
  endtask

  initial begin
    reset            = 1'b1;
    bus.start        = 1'b0;
    bus.sector_a     = '0;
    bus.sector_b     = '0;
    bus.result_ready = 1'b0;
    for (int s = 0; s < 16; s++) fill(s, 16'h0000);
    fill(2, 16'h0100);
    fill(5, 16'h0100);
    fill(3, 16'hff00);
    fill(7, 16'h7fff);
    fill(9, 16'h8000);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    check("rst_busy", bus.busy, 1'b0);
    check("rst_valid", bus.result_valid, 1'b0);
    check("rst_result", {bus.result, 15'd0, bus.overflow}, 32'h0);
    check("rst_addr", {bus.read_add_1, bus.read_add_2, bus.read_sector_selector_1,
                       bus.read_sector_selector_2}, 32'h0);

    // Identity sum with address stepping and latency.
    run(4'd2, 4'd5, 1'b1, lat);
    check("ident_latency", lat, 32'd19);
    check("ident_result", bus.result, 16'h1000);
    check("ident_ovf", bus.overflow, 1'b0);
    accept();
    check("ident_hold", bus.result, 16'h1000);

    // Negative sum.
    run(4'd3, 4'd5, 1'b0, lat);
`ifdef DOT_PRODUCT_RELU_EN
    check("neg_result", bus.result, 16'h0000);
`else
    check("neg_result", bus.result, 16'hf000);
`endif
    check("neg_ovf", bus.overflow, 1'b0);
    accept();

    // Positive saturation.
    run(4'd7, 4'd7, 1'b0, lat);
    check("sat_result", bus.result, 16'h7fff);
    check("sat_ovf", bus.overflow, 1'b1);
    accept();

    // Negative saturation.
    run(4'd9, 4'd7, 1'b0, lat);
`ifdef DOT_PRODUCT_RELU_EN
    check("negsat_result", bus.result, 16'h0000);
`else
    check("negsat_result", bus.result, 16'h8000);
`endif
    check("negsat_ovf", bus.overflow, 1'b1);
    accept();

    // Backpressure with start pulsed while waiting in DONE.
    run(4'd2, 4'd5, 1'b0, lat);
    check("bp_latency", lat, 32'd19);
    for (int k = 0; k < 5; k++) begin
      bus.start    = 1'b1;
      bus.sector_a = 4'd7;
      bus.sector_b = 4'd7;
      @(posedge clock);
      #1;
      check("bp_valid", bus.result_valid, 1'b1);
      check("bp_result", {bus.result, 15'd0, bus.overflow}, {16'h1000, 16'h0});
      check("bp_sel", {bus.read_sector_selector_1, bus.read_sector_selector_2}, 8'h25);
    end
    bus.start = 1'b0;
    accept();
    @(posedge clock);
    #1;
    check("bp_idle_stays", bus.busy, 1'b0);
    check("bp_result_hold", bus.result, 16'h1000);

    // Reset during the 6th ISSUE cycle, then rerun.
    bus.start    = 1'b1;
    bus.sector_a = 4'd2;
    bus.sector_b = 4'd5;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    check("mid_addr", bus.read_add_1, 4'd5);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("mid_busy", bus.busy, 1'b0);
    check("mid_valid", bus.result_valid, 1'b0);
    check("mid_addr0", {bus.read_add_1, bus.read_add_2, bus.read_sector_selector_1,
                        bus.read_sector_selector_2}, 32'h0);
    run(4'd2, 4'd5, 1'b0, lat);
    check("rerun_latency", lat, 32'd19);
    check("rerun_result", bus.result, 16'h1000);
    check("rerun_ovf", bus.overflow, 1'b0);
    accept();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/dot_product_sequencer.md
Name: dot_product_sequencer

Overview:
- Downstream consumer of the 16-sector, dual-read-port weight/activation memory.
- Drives both read ports to stream two 16-entry vectors, one element pair per cycle: vector A from sector_a, vector B from sector_b.
- Multiplies the pairs as signed Q-format values, accumulates them, then rescales and saturates the sum to 16 bits.
- Presents the result to the next autoencoder layer stage through a valid/ready handshake.

Parameters:
- VEC_LEN, 16: elements per dot product. Legal range 1..16, because addresses are 4 bits.
- FRAC_BITS, 8: fractional bits of the signed Q-format, for operands and result.
- READ_LATENCY, 1: clock cycles from address/selector presented to read_data valid.
- ACC_WIDTH, 40: signed accumulator width. Must be at least 32 + ceil(log2(VEC_LEN)).

Ports:
- clock, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- start, input, 1: begin one dot product. Sampled only in IDLE.
- sector_a, input, 4: sector for vector A. Captured when start is accepted.
- sector_b, input, 4: sector for vector B. Captured when start is accepted.
- busy, output, 1: high in every state except IDLE.
- read_add_1, output, 4: element address, read port 1.
- read_add_2, output, 4: element address, read port 2.
- read_sector_selector_1, output, 4: sector select, read port 1.
- read_sector_selector_2, output, 4: sector select, read port 2.
- read_data_1, input, 16: vector A element, signed.
- read_data_2, input, 16: vector B element, signed.
- result, output, 16: signed saturated dot product.
- result_valid, output, 1: result available.
- result_ready, input, 1: downstream accepts result.
- overflow, output, 1: saturation occurred. Valid with result.

Behaviour:
- Reset values: all outputs 0, state IDLE, accumulator 0, address counter 0, latency pipe cleared.
- Reset mid-operation: same as reset. The operation in flight is abandoned and no result is produced.
- IDLE:
  - When start=1, capture sector_a and sector_b, clear the accumulator and counter, and go to ISSUE.
  - start while not in IDLE is ignored.
- ISSUE (VEC_LEN cycles):
  - read_add_1 = read_add_2 = counter.
  - read_sector_selector_1 = captured sector_a; read_sector_selector_2 = captured sector_b.
  - Counter increments each cycle from 0 to VEC_LEN-1.
  - After the cycle with counter = VEC_LEN-1, go to DRAIN.
  - The counter never wraps within an operation.
- Read tracking:
  - A READ_LATENCY-deep valid shift register tags each issued read.
  - On the cycle a tagged read_data pair arrives, the full 32-bit signed product read_data_1 × read_data_2 is sign-extended and added to the accumulator.
- DRAIN (READ_LATENCY cycles):
  - No new reads are issued.
  - Address and selector outputs hold their last values.
  - Remaining products are accumulated.
  - Then go to SCALE.
- SCALE (1 cycle):
  - Arithmetic right shift of the accumulator by FRAC_BITS (truncation toward minus infinity).
  - Saturate to the range [-32768, 32767].
  - overflow = 1 if clamping occurred.
  - Register result and overflow, then go to DONE.
- DONE:
  - result_valid = 1.
  - result and overflow are held stable while result_valid=1 and result_ready=0.
  - Handshake completes on a cycle with result_valid=1 and result_ready=1. Next state is IDLE, result_valid drops, and result holds its last value.
  - result_ready is ignored outside DONE.
- Latency: result_valid rises VEC_LEN + READ_LATENCY + 2 cycles after the edge that samples start (19 at defaults).
- Back-to-back operation: the earliest next start is the cycle after the handshake.

Optional Feature:
- Macro: DOT_PRODUCT_RELU_EN.
- Defined: SCALE applies ReLU after saturation, so any negative saturated value becomes 0x0000. overflow still reports positive clamping; negative clamping reports overflow=1 and result=0.
- Undefined: result is the signed saturated value.

Test Plan:
- Identity sum, default parameters: all 16 entries of sector 2 and sector 5 = 0x0100; start with sector_a=2, sector_b=5.
  - Required: read_add_1 and read_add_2 step 0..15 with selectors 2 and 5.
  - Required: result=0x1000, overflow=0, result_valid rises 19 cycles after start.
- Negative sum: A entries = 0xFF00, B entries = 0x0100.
  - Without the macro: result=0xF000, overflow=0.
  - With DOT_PRODUCT_RELU_EN: result=0x0000, overflow=0.
- Saturation: all entries = 0x7FFF.
  - Required: result=0x7FFF, overflow=1.
- Negative saturation: A = 0x8000, B = 0x7FFF.
  - Required: result=0x8000, overflow=1.
- Backpressure: hold result_ready=0 for 5 cycles in DONE and pulse start during them.
  - Required: result and result_valid stable, start ignored, IDLE entered one cycle after result_ready=1.
- Reset mid-operation: assert reset during the 6th ISSUE cycle.
  - Required: next cycle busy=0, result_valid=0, all addresses 0.
  - Required: the identity-sum test rerun immediately afterwards returns 0x1000.
